// File: rtl/rob_slot_scheduler.sv
// ROB slot table controller: grants AXI read IDs a slot, tracks occupancy, drains on request.
// Build option ROB_SLOT_REUSE_EN: same-ID requests share their owning slot through a counter.
module rob_slot_entry #(
    parameter int ID_WIDTH  = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 take_new,
    input  logic                 take_reuse,
    input  logic                 release_one,
    input  logic [ID_WIDTH-1:0]  id,
    output logic                 alloc,
    output logic [ID_WIDTH-1:0]  owner,
    output logic [CNT_WIDTH-1:0] cnt
);
    // release_one is only raised for an allocated slot, so take_new never meets it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alloc <= 1'b0;
            owner <= '0;
            cnt   <= '0;
        end else if (take_new) begin
            alloc <= 1'b1;
            owner <= id;
            cnt   <= CNT_WIDTH'(1);
        end else if (take_reuse && !release_one) begin
            cnt <= cnt + 1'b1;
        end else if (release_one && !take_reuse) begin
            cnt <= cnt - 1'b1;
            if (cnt == CNT_WIDTH'(1))
                alloc <= 1'b0;
        end
    end
endmodule

module rob_slot_scheduler #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               alloc_valid,
    input  logic [ID_WIDTH-1:0]                alloc_id,
    output logic                               alloc_ready,
    output logic                               grant_valid,
    output logic [$clog2(MAX_OUTSTANDING)-1:0] grant_slot,
    output logic [ID_WIDTH-1:0]                grant_id,
    output logic                               grant_reuse,
    input  logic                               free_valid,
    input  logic [$clog2(MAX_OUTSTANDING)-1:0] free_slot,
    output logic                               err_free,
    input  logic                               drain_req,
    output logic                               drain_done,
    output logic [$clog2(MAX_OUTSTANDING):0]   free_count,
    output logic                               full
);
    localparam int SW = $clog2(MAX_OUTSTANDING);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
`ifdef ROB_SLOT_REUSE_EN
    localparam bit REUSE_EN = 1'b1;
`else
    localparam bit REUSE_EN = 1'b0;
`endif

    typedef enum logic {RUN, DRAIN} state_t;
    typedef struct packed {
        logic [SW-1:0]       slot;
        logic [ID_WIDTH-1:0] id;
        logic                reuse;
    } grant_t;

    state_t state, state_next;
    logic   drain_fire;

    logic [MAX_OUTSTANDING-1:0]                alloc;
    logic [MAX_OUTSTANDING-1:0][ID_WIDTH-1:0]  owner;
    logic [MAX_OUTSTANDING-1:0][CNT_WIDTH-1:0] cnt;
    logic [MAX_OUTSTANDING-1:0]                take_new, take_reuse, release_one;

    logic          match_hit, free_hit, use_match, hs, free_gone;
    logic [SW-1:0] match_idx, free_idx;
    grant_t        grant_q, grant_d;

    // Descending scan so the lowest qualifying index wins
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        free_hit  = 1'b0;
        free_idx  = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (alloc[i] && owner[i] == alloc_id) begin
                match_hit = 1'b1;
                match_idx = SW'(i);
            end
            if (!alloc[i]) begin
                free_hit = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    // A saturated owner stalls rather than opening a second slot for the same ID
    assign use_match   = REUSE_EN && match_hit;
    assign alloc_ready = rst_n && (state == RUN) &&
                         (use_match ? (cnt[match_idx] < CNT_MAX) : free_hit);
    assign hs          = alloc_valid && alloc_ready;

    always_comb begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            take_new[i]    = hs && !use_match && (free_idx == SW'(i));
            take_reuse[i]  = hs && use_match && (match_idx == SW'(i));
            release_one[i] = free_valid && (free_slot == SW'(i)) && alloc[i];
        end
    end

    for (genvar g = 0; g < MAX_OUTSTANDING; g++) begin : g_slot
        rob_slot_entry #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .take_new    (take_new[g]),
            .take_reuse  (take_reuse[g]),
            .release_one (release_one[g]),
            .id          (alloc_id),
            .alloc       (alloc[g]),
            .owner       (owner[g]),
            .cnt         (cnt[g])
        );
    end

    assign free_gone = release_one[free_slot] && (cnt[free_slot] == CNT_WIDTH'(1)) &&
                       !take_reuse[free_slot];

    assign grant_d.slot  = use_match ? match_idx : free_idx;
    assign grant_d.id    = alloc_id;
    assign grant_d.reuse = use_match;

    always_comb begin
        state_next = state;
        drain_fire = 1'b0;
        case (state)
            RUN:   if (drain_req) state_next = DRAIN;
            DRAIN: if (free_count == (SW+1)'(MAX_OUTSTANDING) && !free_valid) begin
                state_next = RUN;
                drain_fire = 1'b1;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            grant_valid <= 1'b0;
            grant_q     <= '0;
            err_free    <= 1'b0;
            drain_done  <= 1'b0;
            free_count  <= (SW+1)'(MAX_OUTSTANDING);
        end else begin
            state       <= state_next;
            grant_valid <= hs;
            if (hs)
                grant_q <= grant_d;
            err_free    <= free_valid && !alloc[free_slot];
            drain_done  <= drain_fire;
            free_count  <= free_count - (SW+1)'(hs && !use_match) + (SW+1)'(free_gone);
        end
    end

    assign grant_slot  = grant_q.slot;
    assign grant_id    = grant_q.id;
    assign grant_reuse = grant_q.reuse;
    assign full        = (free_count == '0);
endmodule

// File: tb/tb_rob_slot_scheduler.sv
// Directed bench for rob_slot_scheduler; expectations follow ROB_SLOT_REUSE_EN when defined.
module tb_rob_slot_scheduler;
    localparam int IDW = 5;
    localparam int N   = 16;
    localparam int SW  = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           alloc_valid;
    logic [IDW-1:0] alloc_id;
    logic           alloc_ready;
    logic           grant_valid;
    logic [SW-1:0]  grant_slot;
    logic [IDW-1:0] grant_id;
    logic           grant_reuse;
    logic           free_valid;
    logic [SW-1:0]  free_slot;
    logic           err_free;
    logic           drain_req;
    logic           drain_done;
    logic [SW:0]    free_count;
    logic           full;

    int n_total = 0;
    int n_bad   = 0;

    rob_slot_scheduler #(.ID_WIDTH(IDW), .MAX_OUTSTANDING(N), .CNT_WIDTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_id    (alloc_id),
        .alloc_ready (alloc_ready),
        .grant_valid (grant_valid),
        .grant_slot  (grant_slot),
        .grant_id    (grant_id),
        .grant_reuse (grant_reuse),
        .free_valid  (free_valid),
        .free_slot   (free_slot),
        .err_free    (err_free),
        .drain_req   (drain_req),
        .drain_done  (drain_done),
        .free_count  (free_count),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; alloc_valid = 1'b0; free_valid = 1'b0; drain_req = 1'b0;
        tick;
        rst_n = 1'b1;
    endtask

    task automatic alloc(input logic [IDW-1:0] id, input int slot, input bit reuse);
        alloc_valid = 1'b1;
        alloc_id    = id;
        #1;
        chk("alloc_ready", 32'(alloc_ready), 1);
        tick;
        chk("grant_valid", 32'(grant_valid), 1);
        chk("grant_slot", 32'(grant_slot), 32'(slot));
        chk("grant_id", 32'(grant_id), 32'(id));
        chk("grant_reuse", 32'(grant_reuse), 32'(reuse));
        alloc_valid = 1'b0;
    endtask

    task automatic free(input int slot);
        free_valid = 1'b1;
        free_slot  = SW'(slot);
        tick;
        free_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=0 exp=1");
        $fatal(1, "timeout");
    end

    initial begin
        alloc_id = '0; free_slot = '0;
        // reset values, including alloc_ready held low
        rst_n = 1'b0; alloc_valid = 1'b1; free_valid = 1'b0; drain_req = 1'b0;
        tick; tick;
        chk("rst_ready", 32'(alloc_ready), 0);
        chk("rst_gv", 32'(grant_valid), 0);
        chk("rst_gslot", 32'(grant_slot), 0);
        chk("rst_fc", 32'(free_count), 16);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err_free), 0);
        chk("rst_dd", 32'(drain_done), 0);
        alloc_valid = 1'b0;
        rst_n = 1'b1;

        // back-to-back IDs 3,5,3
        alloc(3, 0, 0);
        alloc(5, 1, 0);
`ifdef ROB_SLOT_REUSE_EN
        alloc(3, 0, 1);
        chk("b2b_fc", 32'(free_count), 14);
        free(0);
        chk("cnt2_fc", 32'(free_count), 14);
        chk("cnt2_err", 32'(err_free), 0);
        free(0);
        chk("cnt1_fc", 32'(free_count), 15);
        chk("cnt1_err", 32'(err_free), 0);
`else
        alloc(3, 2, 0);
        chk("b2b_fc", 32'(free_count), 13);
        free(0);
        chk("rel_fc", 32'(free_count), 14);
        chk("rel_err", 32'(err_free), 0);
        free(0);
        chk("twice_fc", 32'(free_count), 14);
        chk("twice_err", 32'(err_free), 1);
`endif

        // fill, stall on full, freed slot 7 visible one cycle later
        do_reset;
        for (int i = 0; i < N; i++) alloc(IDW'(i), i, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_fc", 32'(free_count), 0);
        alloc_valid = 1'b1; alloc_id = 20;
        #1;
        chk("full_ready", 32'(alloc_ready), 0);
        free_valid = 1'b1; free_slot = 7;
        #1;
        chk("freecyc_ready", 32'(alloc_ready), 0);
        tick;
        free_valid = 1'b0;
        chk("after_free_ready", 32'(alloc_ready), 1);
        chk("after_free_gv", 32'(grant_valid), 0);
        tick;
        alloc_valid = 1'b0;
        chk("refill_gv", 32'(grant_valid), 1);
        chk("refill_slot", 32'(grant_slot), 7);
        chk("refill_id", 32'(grant_id), 20);
        chk("refill_full", 32'(full), 1);

        // counter saturation on ID 2
        do_reset;
`ifdef ROB_SLOT_REUSE_EN
        for (int i = 0; i < 15; i++) alloc(2, 0, i != 0);
        chk("sat_fc", 32'(free_count), 15);
        alloc_valid = 1'b1; alloc_id = 2;
        #1;
        chk("sat_ready", 32'(alloc_ready), 0);
        free_valid = 1'b1; free_slot = 0;
        tick;
        free_valid = 1'b0;
        chk("sat_gv", 32'(grant_valid), 0);
        chk("unsat_ready", 32'(alloc_ready), 1);
        tick;
        alloc_valid = 1'b0;
        chk("unsat_gv", 32'(grant_valid), 1);
        chk("unsat_slot", 32'(grant_slot), 0);
        chk("unsat_reuse", 32'(grant_reuse), 1);
        chk("unsat_fc", 32'(free_count), 15);
`else
        for (int i = 0; i < 16; i++) alloc(2, i, 0);
        chk("id2_full", 32'(full), 1);
        alloc_valid = 1'b1; alloc_id = 2;
        #1;
        chk("id2_ready", 32'(alloc_ready), 0);
        free_valid = 1'b1; free_slot = 0;
        tick;
        free_valid = 1'b0;
        chk("id2_ready2", 32'(alloc_ready), 1);
        tick;
        alloc_valid = 1'b0;
        chk("id2_slot", 32'(grant_slot), 0);
        chk("id2_reuse", 32'(grant_reuse), 0);
`endif

        // same-cycle alloc and free touching slot 0
        do_reset;
        alloc(4, 0, 0);
        alloc_valid = 1'b1; alloc_id = 4;
        free_valid = 1'b1; free_slot = 0;
        tick;
        alloc_valid = 1'b0; free_valid = 1'b0;
        chk("same_gv", 32'(grant_valid), 1);
        chk("same_fc", 32'(free_count), 15);
        chk("same_err", 32'(err_free), 0);
`ifdef ROB_SLOT_REUSE_EN
        chk("same_slot", 32'(grant_slot), 0);
        chk("same_reuse", 32'(grant_reuse), 1);
        free(0);
        chk("same_cnt1", 32'(free_count), 16);
`else
        chk("same_slot", 32'(grant_slot), 1);
        chk("same_reuse", 32'(grant_reuse), 0);
        free(0);
        chk("same_rel_err", 32'(err_free), 1);
`endif

        // free of an unallocated slot
        do_reset;
        free(9);
        chk("err_pulse", 32'(err_free), 1);
        chk("err_fc", 32'(free_count), 16);
        tick;
        chk("err_once", 32'(err_free), 0);

        // drain with three outstanding
        do_reset;
        alloc(1, 0, 0);
        alloc(2, 1, 0);
        alloc(3, 2, 0);
        drain_req = 1'b1;
        tick;
        drain_req = 1'b0;
        alloc_id = 7;
        #1;
        chk("drain_ready0", 32'(alloc_ready), 0);
        free(0);
        chk("drain_ready1", 32'(alloc_ready), 0);
        free(1);
        chk("drain_ready2", 32'(alloc_ready), 0);
        free(2);
        chk("drain_ready3", 32'(alloc_ready), 0);
        chk("drain_early", 32'(drain_done), 0);
        chk("drain_fc", 32'(free_count), 16);
        tick;
        chk("drain_done", 32'(drain_done), 1);
        chk("drain_run", 32'(alloc_ready), 1);
        tick;
        chk("drain_pulse", 32'(drain_done), 0);

        // reset in the middle of a drain, with a stray free in the reset cycle
        alloc(1, 0, 0);
        drain_req = 1'b1;
        tick;
        rst_n = 1'b0; drain_req = 1'b0;
        free_valid = 1'b1; free_slot = 5;
        tick;
        free_valid = 1'b0;
        chk("mid_fc", 32'(free_count), 16);
        chk("mid_full", 32'(full), 0);
        chk("mid_gv", 32'(grant_valid), 0);
        chk("mid_dd", 32'(drain_done), 0);
        chk("mid_err", 32'(err_free), 0);
        chk("mid_ready", 32'(alloc_ready), 0);
        rst_n = 1'b1;
        #1;
        chk("mid_run", 32'(alloc_ready), 1);
        tick;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
